// File: rtl/avalon_s_ram_device_pkg.sv
// Shared types and constants for the Avalon-MM RAM device.
// Holds the access FSM state encoding and the wait-counter width.
package avalon_s_pkg;

    // Access FSM: IDLE waits for a request, WAIT burns configured wait
    // cycles, ACK is the single cycle in which waitrequest is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Wait-counter width: covers the 0..15 extra wait cycles.
    localparam int CNT_W = 4;

endpackage

// File: rtl/avalon_s_ram_mem.sv
// Single-port RAM: synchronous read with read enable (q holds between
// reads), per-byte write enables. Contents are never reset.
module avalon_s_ram_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic              clk,
    input  logic [IW-1:0]     addr,
    input  logic              re,
    input  logic [DW/8-1:0]   we,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     q
);

    logic [DW-1:0] mem [DEPTH];

    // Byte-lane writes and registered read; q only changes on a read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DW/8; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/avalon_s_ram_device.sv
// Avalon-MM (non-pipelined) RAM window with configurable read/write wait
// states. The host holds its request until it sees waitrequest low, which
// happens in exactly one ACK cycle per access.
// Optional build macro AVALON_S_RAM_STAT_EN adds read/write completion
// counters (stat_rd_cnt, stat_wr_cnt).
// Handshake: a request (avn_read or avn_write high) is accepted in IDLE;
// it completes in the single cycle where avn_waitrequest is 0. Read data is
// valid in that ACK cycle and holds until the next read completes.
// FSM state is available on the internal signal 'state' for checkers.
module avalon_s_ram_device
    import avalon_s_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 1024,
    parameter int BASE    = 0,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avn_read,
    input  logic              avn_write,
    input  logic [AW-1:0]     avn_address,
    input  logic [DW/8-1:0]   avn_byte_enable,
    input  logic [DW-1:0]     avn_writedata,
    output logic [DW-1:0]     avn_readdata,
`ifdef AVALON_S_RAM_STAT_EN
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
`endif
    output logic              avn_waitrequest
);

    localparam int BW  = DW / 8;
    localparam int BSH = (BW > 1) ? $clog2(BW) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cap_rd;
    logic              cap_hit;
    logic [IW-1:0]     cap_idx;
    logic [BW-1:0]     cap_be;
    logic [DW-1:0]     cap_wd;
    logic              rd_zero;

    // Address decode: offset wraps modulo 2^AW, so addresses below BASE
    // become huge offsets and fall out of range naturally.
    logic [AW-1:0]     req_off;
    logic [AW-1:0]     req_word;
    logic              req_hit;
    logic [IW-1:0]     req_idx;
    logic              req;
    logic [CNT_W-1:0]  load_cnt;

    assign req_off  = avn_address - AW'(BASE);
    assign req_word = req_off >> BSH;
    assign req_hit  = (req_word < AW'(DEPTH));
    assign req_idx  = req_word[IW-1:0];
    assign req      = avn_read | avn_write;
    assign load_cnt = avn_read ? CNT_W'(RD_WAIT) : CNT_W'(WR_WAIT);

    // Transition into ACK and the attributes of the access making it.
    logic              go_ack;
    logic              op_rd;
    logic              op_hit;
    logic [IW-1:0]     mem_addr;
    logic              mem_re;
    logic [BW-1:0]     mem_we;
    logic [DW-1:0]     mem_q;

    assign go_ack   = req && (((state == IDLE) && (load_cnt == '0)) ||
                              ((state == WAIT) && (wait_cnt == CNT_W'(1))));
    assign op_rd    = (state == IDLE) ? avn_read : cap_rd;
    assign op_hit   = (state == IDLE) ? req_hit  : cap_hit;
    assign mem_addr = (state == IDLE) ? req_idx  : cap_idx;
    assign mem_re   = rst && go_ack && op_rd && op_hit;
    assign mem_we   = (rst && (state == ACK) && !cap_rd && cap_hit) ? cap_be : '0;

    avalon_s_ram_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .addr  (mem_addr),
        .re    (mem_re),
        .we    (mem_we),
        .wdata (cap_wd),
        .q     (mem_q)
    );

    // Read data is the RAM output register, forced to zero after reset or
    // after an out-of-range read; both sources only change on read completion.
    assign avn_readdata = rd_zero ? '0 : mem_q;

    // Track whether the most recent completed read returned zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_zero <= 1'b1;
        end else if (go_ack && op_rd) begin
            rd_zero <= !op_hit;
        end
    end

    // Access FSM with registered waitrequest (low only while in ACK).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            avn_waitrequest <= 1'b1;
            cap_rd          <= 1'b0;
            cap_hit         <= 1'b0;
            cap_idx         <= '0;
            cap_be          <= '0;
            cap_wd          <= '0;
        end else begin
            avn_waitrequest <= 1'b1;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_rd  <= avn_read;
                        cap_hit <= req_hit;
                        cap_idx <= req_idx;
                        cap_be  <= avn_byte_enable;
                        cap_wd  <= avn_writedata;
                        if (load_cnt != '0) begin
                            wait_cnt <= load_cnt;
                            state    <= WAIT;
                        end else begin
                            state           <= ACK;
                            avn_waitrequest <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt == CNT_W'(1)) begin
                        wait_cnt        <= '0;
                        state           <= ACK;
                        avn_waitrequest <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AVALON_S_RAM_STAT_EN
    // Count completed accesses in their ACK cycle, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
        end else if (state == ACK) begin
            if (cap_rd) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end else begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
